// File: rtl/vga_tile_scanout.sv
// vga_tile_scanout: 640x480@60 VGA scanout reading one tile colour per visible
// pixel from an external tile RAM (1-cycle read latency), emitting RGB332 with
// hsync/vsync delayed to stay aligned with the pixel data.
//
// Optional build macro: SCANOUT_GRIDLINES_EN
//   defined   -> first row/column of every tile is forced black (1-pixel borders)
//   undefined -> tile colour fills every visible pixel
//
// Pipeline:
//   stage 0: hcnt/vcnt, re/raddr, vblank, frame_start (all aligned to the counters)
//   stage 1: RAM registers rdata; visible/sync/gridline flags delayed one cycle
//   stage 2: RGB and sync output registers
module vga_tile_scanout #(
    parameter int dwidth     = 8,
    parameter int addr_width = 11,
    parameter int TILE_SHIFT = 4,
    parameter int GRID_COLS  = 40,
    parameter int GRID_ROWS  = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  re,
    output logic [addr_width-1:0] raddr,
    input  logic [dwidth-1:0]     rdata,
    output logic                  hsync,
    output logic                  vsync,
    output logic [2:0]            red,
    output logic [2:0]            green,
    output logic [1:0]            blue,
    output logic                  vblank,
    output logic                  frame_start
);

    localparam logic [9:0] H_VIS        = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_MAX        = 10'd799;
    localparam logic [9:0] V_VIS        = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_MAX        = 10'd524;

    localparam logic [9:0]            GRID_COLS_W = 10'(GRID_COLS);
    localparam logic [9:0]            GRID_ROWS_W = 10'(GRID_ROWS);
    localparam logic [addr_width-1:0] ROW_STEP    = addr_width'(GRID_COLS);

    // stage 0 state
    logic [9:0]            hcnt_q, hcnt_d;
    logic [9:0]            vcnt_q, vcnt_d;
    logic [addr_width-1:0] row_base_q, row_base_d;
    logic [addr_width-1:0] raddr_q, raddr_d;
    logic [addr_width-1:0] col_d;
    logic                  re_q, re_d;
    logic                  vblank_q, vblank_d;
    logic                  frame_start_q, frame_start_d;
    logic                  line_wrap;

    // raw flags decoded from the current counters
    logic                  hs_raw;
    logic                  vs_raw;

    // stage 1 / stage 2 state
    logic                  vis1_q, vis1_d;
    logic                  hs1_q, hs1_d;
    logic                  vs1_q, vs1_d;
    logic [7:0]            rgb_q, rgb_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;

`ifdef SCANOUT_GRIDLINES_EN
    logic                  grid_raw;
    logic                  grid1_q, grid1_d;
`endif

    // Next counter values; the row base tracks (vcnt>>TILE_SHIFT)*GRID_COLS
    // incrementally so no multiplier is needed.
    always_comb begin
        hcnt_d     = hcnt_q + 10'd1;
        vcnt_d     = vcnt_q;
        row_base_d = row_base_q;
        line_wrap  = (hcnt_q == H_MAX);
        if (line_wrap) begin
            hcnt_d = '0;
            if (vcnt_q == V_MAX) begin
                vcnt_d     = '0;
                row_base_d = '0;
            end else begin
                vcnt_d = vcnt_q + 10'd1;
                if (vcnt_d[TILE_SHIFT-1:0] == '0) begin
                    row_base_d = row_base_q + ROW_STEP;
                end
            end
        end
    end

    // Stage 0 outputs computed from the next counter values so they register
    // in the same cycle the counters show that position.
    always_comb begin
        col_d = addr_width'(hcnt_d >> TILE_SHIFT);
        re_d  = (hcnt_d < H_VIS) && (vcnt_d < V_VIS) &&
                ((hcnt_d >> TILE_SHIFT) < GRID_COLS_W) &&
                ((vcnt_d >> TILE_SHIFT) < GRID_ROWS_W);
        raddr_d = raddr_q;
        if (re_d) begin
            raddr_d = row_base_d + col_d;
        end
        vblank_d      = (vcnt_d >= V_VIS);
        frame_start_d = line_wrap && (vcnt_q == V_MAX);
    end

    // Counter, row base and read-port registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            row_base_q    <= '0;
            raddr_q       <= '0;
            re_q          <= 1'b0;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            row_base_q    <= row_base_d;
            raddr_q       <= raddr_d;
            re_q          <= re_d;
            vblank_q      <= vblank_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Raw sync (and gridline) flags decoded from the counter stage.
    always_comb begin
        hs_raw = (hcnt_q >= H_SYNC_START) && (hcnt_q <= H_SYNC_END);
        vs_raw = (vcnt_q >= V_SYNC_START) && (vcnt_q <= V_SYNC_END);
`ifdef SCANOUT_GRIDLINES_EN
        grid_raw = (hcnt_q[TILE_SHIFT-1:0] == '0) || (vcnt_q[TILE_SHIFT-1:0] == '0);
`endif
    end

    // Stage 1 next values: flags travel alongside the RAM read.
    always_comb begin
        vis1_d = re_q;
        hs1_d  = hs_raw;
        vs1_d  = vs_raw;
`ifdef SCANOUT_GRIDLINES_EN
        grid1_d = grid_raw;
`endif
    end

    // Stage 1 flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vis1_q <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
`ifdef SCANOUT_GRIDLINES_EN
            grid1_q <= 1'b0;
`endif
        end else begin
            vis1_q <= vis1_d;
            hs1_q  <= hs1_d;
            vs1_q  <= vs1_d;
`ifdef SCANOUT_GRIDLINES_EN
            grid1_q <= grid1_d;
`endif
        end
    end

    // Stage 2 next values: pixel colour gated to black outside the visible area.
    always_comb begin
        rgb_d = '0;
`ifdef SCANOUT_GRIDLINES_EN
        if (vis1_q && !grid1_q) begin
            rgb_d = rdata[7:0];
        end
`else
        if (vis1_q) begin
            rgb_d = rdata[7:0];
        end
`endif
        hsync_d = ~hs1_q;
        vsync_d = ~vs1_q;
    end

    // Stage 2 output registers; syncs idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign re          = re_q;
    assign raddr       = raddr_q;
    assign red         = rgb_q[7:5];
    assign green       = rgb_q[4:2];
    assign blue        = rgb_q[1:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vblank      = vblank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_tile_scanout.sv
// Testbench for vga_tile_scanout: tile RAM model plus a reference model that
// derives every output from the elapsed clock count since reset release.
module tb_vga_tile_scanout;

    logic        clk;
    logic        reset;
    logic        re;
    logic [10:0] raddr;
    logic [7:0]  rdata;
    logic        hsync;
    logic        vsync;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic        vblank;
    logic        frame_start;

    logic [7:0]  mem [0:2047];

    int          n_tests;
    int          n_fail;
    int          t;
    logic [10:0] m_raddr;

    vga_tile_scanout dut (
        .clk         (clk),
        .reset       (reset),
        .re          (re),
        .raddr       (raddr),
        .rdata       (rdata),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tile RAM: registered read, one cycle latency
    always @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

    function automatic int hpos(input int k);
        return k % 800;
    endfunction

    function automatic int vpos(input int k);
        return (k / 800) % 525;
    endfunction

    function automatic logic [7:0] exp_pix(input int k);
        int h;
        int v;
        if (k < 1) return 8'h00;
        h = hpos(k);
        v = vpos(k);
        if (h >= 640 || v >= 480) return 8'h00;
`ifdef SCANOUT_GRIDLINES_EN
        if ((h % 16) == 0 || (v % 16) == 0) return 8'h00;
`endif
        return mem[(v / 16) * 40 + (h / 16)];
    endfunction

    task automatic fill_mem(input int mode, input logic [7:0] val);
        for (int i = 0; i < 2048; i++) begin
            if (mode == 0) mem[i] = val;
            else mem[i] = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        t       = 0;
        m_raddr = '0;
    endtask

    // Advance n clocks, comparing every output with the model at each step.
    task automatic run_check(input int n);
        logic [7:0] e_pix;
        logic       e_hs;
        logic       e_vs;
        logic       e_re;
        int         k;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            k     = t - 2;
            e_pix = exp_pix(k);
            e_hs  = !(k >= 0 && hpos(k) >= 656 && hpos(k) <= 751);
            e_vs  = !(k >= 0 && vpos(k) >= 490 && vpos(k) <= 491);
            e_re  = (t >= 1) && hpos(t) < 640 && vpos(t) < 480;
            if (e_re) m_raddr = 11'((vpos(t) / 16) * 40 + hpos(t) / 16);

            n_tests++;
            if ({red, green, blue} !== e_pix) begin
                n_fail++;
                $display("FAIL pixel t=%0d got %h want %h", t, {red, green, blue}, e_pix);
            end
            n_tests++;
            if ({hsync, vsync} !== {e_hs, e_vs}) begin
                n_fail++;
                $display("FAIL sync t=%0d got %b%b want %b%b", t, hsync, vsync, e_hs, e_vs);
            end
            n_tests++;
            if ({re, raddr} !== {e_re, m_raddr}) begin
                n_fail++;
                $display("FAIL read_port t=%0d got re=%b raddr=%0d want re=%b raddr=%0d",
                         t, re, raddr, e_re, m_raddr);
            end
            n_tests++;
            if ({vblank, frame_start} !== {vpos(t) >= 480, (t >= 1) && hpos(t) == 0 && vpos(t) == 0}) begin
                n_fail++;
                $display("FAIL status t=%0d got vblank=%b frame_start=%b", t, vblank, frame_start);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        n_tests++;
        if ({re, raddr, red, green, blue, hsync, vsync, vblank, frame_start} !==
            {1'b0, 11'd0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s got re=%b raddr=%0d rgb=%h hs=%b vs=%b vb=%b fs=%b want 0/0/00/1/1/0/0",
                     name, re, raddr, {red, green, blue}, hsync, vsync, vblank, frame_start);
        end
    endtask

    task automatic test_reset();
        fill_mem(1, 8'h00);
        reset = 1'b1;
        #3;
        check_reset_values("reset_async");
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset_held");
        reset   = 1'b0;
        t       = 0;
        m_raddr = '0;
        run_check(60);
    endtask

    task automatic test_tile_pixel();
        logic [7:0] e_tile;
        fill_mem(0, 8'h00);
        mem[41] = 8'hE0;
        do_reset();
        run_check(16 * 800 + 16);
        n_tests++;
        if ({re, raddr} !== {1'b1, 11'd41}) begin
            n_fail++;
            $display("FAIL tile_addr got re=%b raddr=%0d want re=1 raddr=41", re, raddr);
        end
        run_check(1);
        n_tests++;
        if ({red, green, blue} !== 8'h00) begin
            n_fail++;
            $display("FAIL pixel_15_16 got %h want 00", {red, green, blue});
        end
        run_check(1);
`ifdef SCANOUT_GRIDLINES_EN
        e_tile = 8'h00;
`else
        e_tile = 8'hE0;
`endif
        n_tests++;
        if ({red, green, blue} !== e_tile) begin
            n_fail++;
            $display("FAIL pixel_16_16 got %h want %h", {red, green, blue}, e_tile);
        end
        run_check(40);
    endtask

    task automatic test_blanking();
        int bad;
        fill_mem(0, 8'hFF);
        do_reset();
        bad = 0;
        for (int i = 0; i < 2400; i++) begin
            run_check(1);
            if (hpos(t) >= 640 && re !== 1'b0) bad++;
            if (t >= 2 && hpos(t - 2) >= 640 && {red, green, blue} !== 8'h00) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL blanking got %0d violations want 0", bad);
        end
    endtask

    task automatic test_address_sweep();
        fill_mem(1, 8'h00);
        do_reset();
        run_check(639);
        n_tests++;
        if ({re, raddr} !== {1'b1, 11'd39}) begin
            n_fail++;
            $display("FAIL raddr_639_0 got re=%b raddr=%0d want re=1 raddr=39", re, raddr);
        end
        run_check(1);
        n_tests++;
        if ({re, raddr} !== {1'b0, 11'd39}) begin
            n_fail++;
            $display("FAIL raddr_hold got re=%b raddr=%0d want re=0 raddr=39", re, raddr);
        end
        run_check(16 * 800 - 640);
        n_tests++;
        if ({re, raddr} !== {1'b1, 11'd40}) begin
            n_fail++;
            $display("FAIL raddr_0_16 got re=%b raddr=%0d want re=1 raddr=40", re, raddr);
        end
        run_check(1000);
    endtask

    task automatic test_hsync_timing();
        int   falls [3];
        int   widths [2];
        int   nf;
        int   low_start;
        logic prev;
        fill_mem(1, 8'h00);
        do_reset();
        falls  = '{-1, -1, -1};
        widths = '{-1, -1};
        nf        = 0;
        low_start = -1;
        prev      = hsync;
        for (int i = 0; i < 2500; i++) begin
            run_check(1);
            if (prev && !hsync) begin
                if (nf < 3) falls[nf] = t;
                nf++;
                low_start = t;
            end
            if (!prev && hsync && low_start >= 0 && nf >= 1 && nf <= 2) widths[nf-1] = t - low_start;
            prev = hsync;
        end
        n_tests++;
        if (falls[0] != 658) begin
            n_fail++;
            $display("FAIL first_hsync_fall got %0d want 658", falls[0]);
        end
        n_tests++;
        if (falls[1] - falls[0] != 800 || falls[2] - falls[1] != 800) begin
            n_fail++;
            $display("FAIL hsync_period got %0d,%0d want 800,800", falls[1] - falls[0], falls[2] - falls[1]);
        end
        n_tests++;
        if (widths[0] != 96 || widths[1] != 96) begin
            n_fail++;
            $display("FAIL hsync_width got %0d,%0d want 96,96", widths[0], widths[1]);
        end
    endtask

    task automatic test_reset_midframe();
        int   fall;
        logic prev;
        fill_mem(0, 8'hFF);
        do_reset();
        run_check(20 * 800 + 300);
        reset = 1'b1;
        #1;
        check_reset_values("midframe_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("midframe_held");
        reset   = 1'b0;
        t       = 0;
        m_raddr = '0;
        fall    = -1;
        prev    = hsync;
        for (int i = 0; i < 900; i++) begin
            run_check(1);
            if (prev && !hsync && fall < 0) fall = t;
            prev = hsync;
        end
        n_tests++;
        if (fall != 658) begin
            n_fail++;
            $display("FAIL midframe_hsync_fall got %0d want 658", fall);
        end
    endtask

    task automatic test_gridlines();
        logic [7:0] e_edge;
        fill_mem(0, 8'h1C);
        do_reset();
        run_check(5 * 800 + 16 + 2);
`ifdef SCANOUT_GRIDLINES_EN
        e_edge = 8'h00;
`else
        e_edge = 8'h1C;
`endif
        n_tests++;
        if ({red, green, blue} !== e_edge) begin
            n_fail++;
            $display("FAIL pixel_16_5 got %h want %h", {red, green, blue}, e_edge);
        end
        run_check(1);
        n_tests++;
        if ({red, green, blue} !== 8'h1C) begin
            n_fail++;
            $display("FAIL pixel_17_5 got %h want 1c", {red, green, blue});
        end
        run_check(100);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        t       = 0;
        m_raddr = '0;
        reset   = 1'b1;
        test_reset();
        test_tile_pixel();
        test_blanking();
        test_address_sweep();
        test_hsync_timing();
        test_reset_midframe();
        test_gridlines();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
